// File: rtl/ll_multi_module_if.sv
// rtl/ll_multi_module_if.sv - sample/result bundle for the multi-channel line-length extractor
//   Parameters: DATA_WIDTH (sample width), OUTPUT_WIDTH (result width), NUM_CH (channel count)
//   en, din, ch_in          : sample strobe, signed sample, channel tag (driven by master)
//   dout, dout_ch           : LL value and its channel (driven by slave)
//   data_valid              : one-cycle pulse qualifying dout/dout_ch (driven by slave)
//   thresh, det_flag        : detection threshold and flag, present only with LL_MULTI_THRESH_EN
interface ll_multi_module_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_WIDTH = 25,
  parameter int NUM_CH       = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                           en;
  logic signed [DATA_WIDTH-1:0]   din;
  logic        [CH_W-1:0]         ch_in;
  logic        [OUTPUT_WIDTH-1:0] dout;
  logic        [CH_W-1:0]         dout_ch;
  logic                           data_valid;
`ifdef LL_MULTI_THRESH_EN
  logic        [OUTPUT_WIDTH-1:0] thresh;
  logic                           det_flag;

  modport master (output en, din, ch_in, thresh, input dout, dout_ch, data_valid, det_flag);
  modport slave  (input en, din, ch_in, thresh, output dout, dout_ch, data_valid, det_flag);
`else
  modport master (output en, din, ch_in, input dout, dout_ch, data_valid);
  modport slave  (input en, din, ch_in, output dout, dout_ch, data_valid);
`endif
endinterface

// File: rtl/ll_multi_module.sv
// rtl/ll_multi_module.sv - multi-channel windowed line-length feature extractor
//   clk   : clock, rising edge
//   rst   : synchronous active-low reset
//   bus   : ll_multi_module_if.slave (en/din/ch_in in; dout/dout_ch/data_valid out)
//   Optional macro LL_MULTI_THRESH_EN adds bus.thresh (in) and bus.det_flag (out).
module ll_multi_module #(
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_WIDTH = 25,
  parameter int NUM_CH       = 4,
  parameter int WIN_LEN      = 64,
  parameter int MEAN_MODE    = 0
) (
  input  logic               clk,
  input  logic               rst,
  ll_multi_module_if.slave   bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LOG2W  = $clog2(WIN_LEN);
  localparam int DIFF_W = DATA_WIDTH + 1;
  localparam int SUM_W  = DIFF_W + LOG2W;
  localparam logic [LOG2W:0] FULL = (LOG2W + 1)'(WIN_LEN);

  generate
    if (OUTPUT_WIDTH < SUM_W || WIN_LEN < 2 || (1 << LOG2W) != WIN_LEN || NUM_CH < 1) begin : g_bad_params
      $error("ll_multi_module: illegal parameter combination");
    end
  endgenerate

  // Per-channel state
  logic signed [DATA_WIDTH-1:0] prev_q [NUM_CH];
  logic        [NUM_CH-1:0]     primed_q;
  logic        [LOG2W:0]        fill_q [NUM_CH];
  logic        [LOG2W-1:0]      wptr_q [NUM_CH];
  logic        [SUM_W-1:0]      sum_q  [NUM_CH];
  logic        [DIFF_W-1:0]     win_q  [NUM_CH][WIN_LEN];

  logic                    accept;
  logic [CH_W-1:0]         idx;
  logic [DIFF_W-1:0]       delta;
  logic [DIFF_W-1:0]       diff;
  logic [DIFF_W-1:0]       oldest;
  logic [SUM_W-1:0]        sum_next;
  logic [LOG2W:0]          fill_next;
  logic [SUM_W-1:0]        ll_val;
  logic [OUTPUT_WIDTH-1:0] dout_next;
  logic                    valid_next;

  always_comb begin
    accept     = bus.en && (int'(bus.ch_in) < NUM_CH);
    // Dropped samples index channel 0 so no array read goes out of range.
    idx        = accept ? bus.ch_in : '0;
    // Sign-extend both operands by one bit so the difference cannot overflow.
    delta      = {bus.din[DATA_WIDTH-1], bus.din} - {prev_q[idx][DATA_WIDTH-1], prev_q[idx]};
    diff       = delta[DIFF_W-1] ? (~delta + 1'b1) : delta;
    // Storage is reset-cleared, so the evicted slot reads 0 until the window wraps.
    oldest     = win_q[idx][wptr_q[idx]];
    sum_next   = sum_q[idx] + SUM_W'(diff) - SUM_W'(oldest);
    fill_next  = (fill_q[idx] == FULL) ? fill_q[idx] : fill_q[idx] + 1'b1;
    valid_next = accept && primed_q[idx] && (fill_next == FULL);
    ll_val     = (MEAN_MODE != 0) ? (sum_next >> LOG2W) : sum_next;
    dout_next  = OUTPUT_WIDTH'(ll_val);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.dout       <= '0;
      bus.dout_ch    <= '0;
      bus.data_valid <= 1'b0;
`ifdef LL_MULTI_THRESH_EN
      bus.det_flag   <= 1'b0;
`endif
      primed_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        prev_q[c] <= '0;
        fill_q[c] <= '0;
        wptr_q[c] <= '0;
        sum_q[c]  <= '0;
        for (int w = 0; w < WIN_LEN; w++) begin
          win_q[c][w] <= '0;
        end
      end
    end else begin
      bus.data_valid <= valid_next;
`ifdef LL_MULTI_THRESH_EN
      bus.det_flag   <= valid_next && (dout_next > bus.thresh);
`endif
      if (valid_next) begin
        bus.dout    <= dout_next;
        bus.dout_ch <= idx;
      end
      if (accept) begin
        prev_q[idx] <= bus.din;
        if (!primed_q[idx]) begin
          // First sample after reset only seeds prev; there is no diff yet.
          primed_q[idx] <= 1'b1;
        end else begin
          sum_q[idx]               <= sum_next;
          win_q[idx][wptr_q[idx]]  <= diff;
          wptr_q[idx]              <= wptr_q[idx] + 1'b1;
          fill_q[idx]              <= fill_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_ll_multi_module.sv
// tb/tb_ll_multi_module.sv - directed self-checking bench for ll_multi_module
module tb_ll_multi_module;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  // b0: sum mode, 2 ch; b1: mean mode, 2 ch; b3: sum mode, 3 ch (out-of-range tag reachable)
  ll_multi_module_if #(.DATA_WIDTH(16), .OUTPUT_WIDTH(25), .NUM_CH(2)) b0 ();
  ll_multi_module_if #(.DATA_WIDTH(16), .OUTPUT_WIDTH(25), .NUM_CH(2)) b1 ();
  ll_multi_module_if #(.DATA_WIDTH(16), .OUTPUT_WIDTH(25), .NUM_CH(3)) b3 ();

  ll_multi_module #(.DATA_WIDTH(16), .OUTPUT_WIDTH(25), .NUM_CH(2), .WIN_LEN(4), .MEAN_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  ll_multi_module #(.DATA_WIDTH(16), .OUTPUT_WIDTH(25), .NUM_CH(2), .WIN_LEN(4), .MEAN_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  ll_multi_module #(.DATA_WIDTH(16), .OUTPUT_WIDTH(25), .NUM_CH(3), .WIN_LEN(4), .MEAN_MODE(0))
    dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  task automatic step(input logic e, input int ch, input int val);
    @(negedge clk);
    b0.en = e; b0.ch_in = 1'(ch); b0.din = 16'(val);
    b1.en = e; b1.ch_in = 1'(ch); b1.din = 16'(val);
    b3.en = e; b3.ch_in = 2'(ch); b3.din = 16'(val);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    b0.en = 1'b0; b1.en = 1'b0; b3.en = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++; if (b0.data_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0d expected 0", b0.data_valid); end
    nchk++; if (b0.dout !== 25'd0) begin nerr++; $display("FAIL reset_dout: got %0d expected 0", b0.dout); end
    nchk++; if (b0.dout_ch !== 1'b0) begin nerr++; $display("FAIL reset_dout_ch: got %0d expected 0", b0.dout_ch); end
    nchk++; if (b3.data_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid3: got %0d expected 0", b3.data_valid); end
`ifdef LL_MULTI_THRESH_EN
    nchk++; if (b0.det_flag !== 1'b0) begin nerr++; $display("FAIL reset_det: got %0d expected 0", b0.det_flag); end
`endif
  endtask

  task automatic test_basic();
    int s[6];
    logic ev;
    s = '{0, 10, 0, 10, 0, 10};
    do_reset();
`ifdef LL_MULTI_THRESH_EN
    b0.thresh = 25'd39; b1.thresh = 25'd39; b3.thresh = 25'd39;
`endif
    for (int i = 0; i < 6; i++) begin
`ifdef LL_MULTI_THRESH_EN
      if (i == 5) begin b0.thresh = 25'd40; end
`endif
      step(1'b1, 0, s[i]);
      ev = (i >= 4);
      nchk++; if (b0.data_valid !== ev) begin nerr++; $display("FAIL basic_valid[%0d]: got %0d expected %0d", i, b0.data_valid, ev); end
`ifdef LL_MULTI_THRESH_EN
      nchk++; if (b0.det_flag !== (i == 4)) begin nerr++; $display("FAIL basic_det[%0d]: got %0d expected %0d", i, b0.det_flag, (i == 4)); end
`endif
      if (ev) begin
        nchk++; if (b0.dout !== 25'd40) begin nerr++; $display("FAIL basic_dout[%0d]: got %0d expected 40", i, b0.dout); end
        nchk++; if (b0.dout_ch !== 1'b0) begin nerr++; $display("FAIL basic_ch[%0d]: got %0d expected 0", i, b0.dout_ch); end
        nchk++; if (b1.dout !== 25'd10) begin nerr++; $display("FAIL basic_mean[%0d]: got %0d expected 10", i, b1.dout); end
        nchk++; if (b3.dout !== 25'd40) begin nerr++; $display("FAIL basic_dout3[%0d]: got %0d expected 40", i, b3.dout); end
      end
    end
  endtask

  task automatic test_evict();
    int s[6];
    s = '{0, 5, 5, 5, 5, 7};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 0, s[i]);
      nchk++; if (b0.data_valid !== (i >= 4)) begin nerr++; $display("FAIL evict_valid[%0d]: got %0d expected %0d", i, b0.data_valid, (i >= 4)); end
    end
    nchk++; if (b0.dout !== 25'd2) begin nerr++; $display("FAIL evict_dout: got %0d expected 2", b0.dout); end
    step(1'b0, 0, 0);
    nchk++; if (b0.data_valid !== 1'b0) begin nerr++; $display("FAIL idle_valid: got %0d expected 0", b0.data_valid); end
    nchk++; if (b0.dout !== 25'd2) begin nerr++; $display("FAIL idle_hold: got %0d expected 2", b0.dout); end
  endtask

  task automatic test_evict_first();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 0, (i == 0) ? 0 : 5);
    end
    nchk++; if (b0.dout !== 25'd5 || b0.data_valid !== 1'b1) begin nerr++; $display("FAIL evict5: got %0d/%0d expected 5/1", b0.dout, b0.data_valid); end
  endtask

  task automatic test_interleave();
    int a[5];
    int b[5];
    a = '{0, 1, 2, 3, 4};
    b = '{0, -100, 0, -100, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 0, a[i]);
      nchk++; if (b0.data_valid !== (i == 4)) begin nerr++; $display("FAIL il_valid0[%0d]: got %0d expected %0d", i, b0.data_valid, (i == 4)); end
      step(1'b1, 1, b[i]);
      nchk++; if (b0.data_valid !== (i == 4)) begin nerr++; $display("FAIL il_valid1[%0d]: got %0d expected %0d", i, b0.data_valid, (i == 4)); end
    end
    nchk++; if (b0.dout !== 25'd400 || b0.dout_ch !== 1'b1) begin nerr++; $display("FAIL il_ch1: got %0d ch %0d expected 400 ch 1", b0.dout, b0.dout_ch); end
    nchk++; if (b1.dout !== 25'd100) begin nerr++; $display("FAIL il_mean1: got %0d expected 100", b1.dout); end
    nchk++; if (b3.dout !== 25'd400 || b3.dout_ch !== 2'd1) begin nerr++; $display("FAIL il_ch1_3: got %0d ch %0d expected 400 ch 1", b3.dout, b3.dout_ch); end
  endtask

  task automatic test_interleave_ch0();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 0, i);
      if (i < 4) step(1'b1, 1, (i % 2 == 1) ? -100 : 0);
    end
    nchk++; if (b0.dout !== 25'd4 || b0.dout_ch !== 1'b0 || b0.data_valid !== 1'b1) begin nerr++; $display("FAIL il_ch0: got %0d ch %0d v %0d expected 4 ch 0 v 1", b0.dout, b0.dout_ch, b0.data_valid); end
  endtask

  task automatic test_extreme();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1, (i % 2 == 0) ? 32767 : -32768);
      nchk++; if (b0.data_valid !== (i >= 4)) begin nerr++; $display("FAIL ext_valid[%0d]: got %0d expected %0d", i, b0.data_valid, (i >= 4)); end
      if (i >= 4) begin
        nchk++; if (b0.dout !== 25'd262140) begin nerr++; $display("FAIL ext_sum[%0d]: got %0d expected 262140", i, b0.dout); end
        nchk++; if (b1.dout !== 25'd65535) begin nerr++; $display("FAIL ext_mean[%0d]: got %0d expected 65535", i, b1.dout); end
        nchk++; if (b0.dout_ch !== 1'b1) begin nerr++; $display("FAIL ext_ch[%0d]: got %0d expected 1", i, b0.dout_ch); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int s[5];
    s = '{0, 3, 0, 3, 0};
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    nchk++; if (b0.dout !== 25'd0 || b0.data_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst: got %0d/%0d expected 0/0", b0.dout, b0.data_valid); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 0, s[i]);
      nchk++; if (b0.data_valid !== (i == 4)) begin nerr++; $display("FAIL mid_valid[%0d]: got %0d expected %0d", i, b0.data_valid, (i == 4)); end
      if (i < 4) begin
        nchk++; if (b0.dout !== 25'd0) begin nerr++; $display("FAIL mid_hold[%0d]: got %0d expected 0", i, b0.dout); end
      end
    end
    nchk++; if (b0.dout !== 25'd12) begin nerr++; $display("FAIL mid_dout: got %0d expected 12", b0.dout); end
    nchk++; if (b3.dout !== 25'd12) begin nerr++; $display("FAIL mid_dout3: got %0d expected 12", b3.dout); end
    // ch1 was full before the reset; it must re-prime now.
    step(1'b1, 1, 0);
    nchk++; if (b0.data_valid !== 1'b0) begin nerr++; $display("FAIL mid_ch1_prime: got %0d expected 0", b0.data_valid); end
  endtask

  task automatic test_bad_ch();
    step(1'b1, 3, 1000);
    nchk++; if (b3.data_valid !== 1'b0) begin nerr++; $display("FAIL badch_valid: got %0d expected 0", b3.data_valid); end
    nchk++; if (b3.dout !== 25'd12 || b3.dout_ch !== 2'd0) begin nerr++; $display("FAIL badch_hold: got %0d ch %0d expected 12 ch 0", b3.dout, b3.dout_ch); end
    step(1'b0, 0, 500);
    nchk++; if (b3.data_valid !== 1'b0) begin nerr++; $display("FAIL en0_valid: got %0d expected 0", b3.data_valid); end
    step(1'b1, 0, 0);
    nchk++; if (b3.data_valid !== 1'b1 || b3.dout !== 25'd9) begin nerr++; $display("FAIL badch_after: got %0d/%0d expected 9/1", b3.dout, b3.data_valid); end
    nchk++; if (b0.data_valid !== 1'b1 || b0.dout !== 25'd9) begin nerr++; $display("FAIL en0_after: got %0d/%0d expected 9/1", b0.dout, b0.data_valid); end
  endtask

  initial begin
    b0.en = 1'b0; b0.din = '0; b0.ch_in = '0;
    b1.en = 1'b0; b1.din = '0; b1.ch_in = '0;
    b3.en = 1'b0; b3.din = '0; b3.ch_in = '0;
`ifdef LL_MULTI_THRESH_EN
    b0.thresh = '0; b1.thresh = '0; b3.thresh = '0;
`endif
    test_reset();
    test_basic();
    test_evict();
    test_evict_first();
    test_interleave();
    test_interleave_ch0();
    test_extreme();
    test_reset_mid();
    test_bad_ch();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
